vm_irq_arbiter: RTL and testbench
=================================

Name: vm_irq_arbiter

Overview:
- Vectored-interrupt arbiter directly upstream of the CPU module's interrupt port.
- Collects NREQ device request lines and drives the CPU virq line.
- On the CPU's vector-fetch strobe (istb) it selects one winning request, returns its 16-bit vector on ivec with iack, and pulses a per-device acknowledge so the device can drop its request.

Parameters:
- NREQ, 8: number of request lines; index 0 has highest fixed priority.
- ROUND_ROBIN, 0: 0 = fixed priority; 1 = rotating priority (the line after the last winner becomes highest).
- SPUR_VEC, 16'o000000: vector returned when istb arrives with no pending request.

Ports:
- clk_p  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- init  in  1  synchronous bus reset (CPU vm_init), active-high.
- req  in  NREQ  device requests, level, synchronous to clk_p.
- vec_flat  in  NREQ*16  vector of line i on bits [16i+15:16i]; must be stable while req[i]=1.
- req_ack  out  NREQ  one-cycle pulse to the granted device.
- virq  out  1  to CPU virq.
- ivec  out  16  to CPU ivec.
- istb  in  1  vector-fetch strobe from CPU.
- iack  out  1  vector-valid acknowledge to CPU.

Behaviour:
- Reset (rst_n=0): state=IDLE, virq=0, iack=0, ivec=0, req_ack=0, rr_ptr=0, all asynchronous.
- States: IDLE, ACK, RELEASE.
- virq is registered. virq <= (state_next==IDLE) & |req, so it drops the cycle after a grant and does not re-trigger during acknowledge.
- IDLE, istb=1 at edge k:
  - winner w = highest-priority set bit of req. Fixed mode: lowest index. RR mode: first set bit scanning from rr_ptr upward, modulo NREQ.
  - At edge k: ivec <= vec_flat[w], req_ack[w] <= 1 for exactly one cycle, iack <= 1, state <= ACK. If ROUND_ROBIN, rr_ptr <= (w+1) mod NREQ; rr_ptr wraps from NREQ-1 to 0.
  - So ivec and iack are valid one clock after istb is first sampled high.
- IDLE, istb=1, req=0: ivec <= SPUR_VEC, iack <= 1, no req_ack, rr_ptr unchanged, state <= ACK.
- ACK:
  - iack and ivec stay held while istb=1.
  - istb=0 sampled: iack <= 0 and state <= IDLE at the same edge.
  - ivec keeps its last value; it is don't-care outside iack.
- Request changes during ACK do not alter ivec.
- A request that drops between virq and istb is not granted. If no other request remains, the spurious path applies.
- Simultaneous requests: exactly one grant per istb cycle. Remaining requests reassert virq the cycle after returning to IDLE.
- init=1 (any state): iack <= 0, req_ack <= 0, virq <= 0. Then state <= RELEASE if istb=1, else IDLE. rr_ptr is kept.
- RELEASE: no grants. iack=0. istb=0 → IDLE. This prevents acking a strobe that started before init.
- istb must not be re-asserted in the same cycle it is seen low. The arbiter needs at least one IDLE cycle between grants.

Decomposition:
- Shared package or header: state encodings (IDLE=2'd0, ACK=2'd1, RELEASE=2'd2) and the default SPUR_VEC.
- One natural sub-module, vm_irq_prio_enc: combinational priority encoder.
  - Inputs: req and rr_ptr.
  - Outputs: winner index, any flag.
  - Instantiated once; fixed mode ties rr_ptr to 0.
- Top: FSM, vector mux and registers.

Test Plan:
- NREQ=8 fixed; req=8'b0010_0100, vec2=16'o000060, vec5=16'o000064; istb up, held 3 cycles.
  - virq=1 before istb.
  - One clock after istb: ivec=000060, iack=1, req_ack=8'b0000_0100 for one cycle.
  - iack drops the edge after istb falls.
  - Second cycle yields 000064 with req_ack[5].
- Spurious grant: req=0, istb pulse → ivec=SPUR_VEC (000000), iack=1, req_ack=0, virq stays 0.
- ROUND_ROBIN=1, req=8'hFF held, four istb cycles → winners 0,1,2,3 in order.
  - With rr_ptr=7 and req=8'h81: winner 7, then 0 (wrap).
- Request withdrawn: req[3]=1 → virq=1; drop req[3] before istb → istb gives SPUR_VEC, no req_ack.
- init during ACK with istb still high → iack=0 next cycle, state RELEASE, no new grant until istb falls and rises again.
- rst_n asserted mid-ACK → virq, iack, ivec, req_ack go 0 immediately, without waiting for a clock edge.
  - After release, a pending request gives virq=1 on the next edge.

Source files
------------

// File: rtl/vm_irq_arbiter_pkg.sv
// vm_irq_arbiter_pkg: shared state encodings and default spurious vector
package vm_irq_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK     = 2'd1,
        RELEASE = 2'd2
    } state_t;
    localparam logic [15:0] SPUR_VEC_DEFAULT = 16'o000000;
endpackage

// File: rtl/vm_irq_prio_enc.sv
// vm_irq_prio_enc: rotating priority encoder, first set request at or above ptr (mod NREQ)
module vm_irq_prio_enc #(
    parameter int NREQ = 8,
    parameter int W    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [W-1:0]    ptr,
    output logic [W-1:0]    win,
    output logic            any
);
    logic [W-1:0] idx;

    assign any = |req;

    // scan from farthest offset down so the closest set bit to ptr is the last write
    always_comb begin
        win = '0;
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = W'((int'(ptr) + i) % NREQ);
            if (req[idx]) win = idx;
        end
    end
endmodule

// File: rtl/vm_irq_arbiter.sv
// vm_irq_arbiter: vectored interrupt arbiter feeding the CPU virq/ivec/iack handshake
module vm_irq_arbiter
    import vm_irq_arbiter_pkg::*;
#(
    parameter int          NREQ        = 8,
    parameter int          ROUND_ROBIN = 0,
    parameter logic [15:0] SPUR_VEC    = SPUR_VEC_DEFAULT
) (
    input  logic             clk_p,
    input  logic             rst_n,
    input  logic             init,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*16-1:0] vec_flat,
    output logic [NREQ-1:0]  req_ack,
    output logic             virq,
    output logic [15:0]      ivec,
    input  logic             istb,
    output logic             iack
);
    localparam int W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [W-1:0] LAST = W'(NREQ - 1);

    state_t          state, state_next;
    logic [W-1:0]    rr_ptr, enc_ptr, win;
    logic            any, fetch, grant;
    logic [15:0]     vec_sel;
    logic [NREQ-1:0] onehot;

    assign enc_ptr = (ROUND_ROBIN != 0) ? rr_ptr : '0;
    assign vec_sel = vec_flat[int'(win) * 16 +: 16];
    assign onehot  = NREQ'(1) << win;

    vm_irq_prio_enc #(.NREQ(NREQ), .W(W)) u_enc (
        .req (req),
        .ptr (enc_ptr),
        .win (win),
        .any (any)
    );

    // next state; init overrides everything and parks in RELEASE if a strobe is already up
    always_comb begin
        state_next = state;
        fetch      = 1'b0;
        grant      = 1'b0;
        if (init) state_next = istb ? RELEASE : IDLE;
        else if (state == IDLE) state_next = istb ? ACK : IDLE;
        else state_next = istb ? state : IDLE;
        fetch = !init && state == IDLE && istb;
        grant = fetch && any;
    end

    // registered outputs, state and rotation pointer
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            virq    <= 1'b0;
            iack    <= 1'b0;
            ivec    <= '0;
            req_ack <= '0;
            rr_ptr  <= '0;
        end else begin
            state   <= state_next;
            virq    <= !init && state_next == IDLE && |req;
            iack    <= state_next == ACK;
            req_ack <= grant ? onehot : '0;
            if (fetch) ivec <= any ? vec_sel : SPUR_VEC;
            if (ROUND_ROBIN != 0 && grant) rr_ptr <= (win == LAST) ? '0 : win + 1'b1;
        end
    end
endmodule

// File: tb/tb_vm_irq_arbiter.sv
// tb_vm_irq_arbiter: directed checks of fixed and rotating priority arbiters
module tb_vm_irq_arbiter;
    logic         clk_p = 1'b0;
    logic         rst_n = 1'b1;
    logic         init  = 1'b0;
    logic [7:0]   req   = '0;
    logic [7:0]   req_r = '0;
    logic         istb  = 1'b0;
    logic         istb_r = 1'b0;
    logic [127:0] vec_flat;
    logic [7:0]   req_ack, req_ack_r;
    logic         virq, virq_r, iack, iack_r;
    logic [15:0]  ivec, ivec_r;
    logic [15:0]  vt [8];
    int           n_cmp = 0;
    int           n_err = 0;

    always #5 clk_p = ~clk_p;

    vm_irq_arbiter #(.NREQ(8), .ROUND_ROBIN(0)) u_fix (
        .clk_p(clk_p), .rst_n(rst_n), .init(init), .req(req), .vec_flat(vec_flat),
        .req_ack(req_ack), .virq(virq), .ivec(ivec), .istb(istb), .iack(iack)
    );

    vm_irq_arbiter #(.NREQ(8), .ROUND_ROBIN(1)) u_rr (
        .clk_p(clk_p), .rst_n(rst_n), .init(init), .req(req_r), .vec_flat(vec_flat),
        .req_ack(req_ack_r), .virq(virq_r), .ivec(ivec_r), .istb(istb_r), .iack(iack_r)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_p);
        #1;
    endtask

    initial begin
        vt[0] = 16'o000100; vt[1] = 16'o000104; vt[2] = 16'o000060; vt[3] = 16'o000110;
        vt[4] = 16'o000114; vt[5] = 16'o000064; vt[6] = 16'o000120; vt[7] = 16'o000124;
        for (int i = 0; i < 8; i++) vec_flat[i*16 +: 16] = vt[i];

        #2 rst_n = 1'b0;
        #1;
        chk("rst_virq", 32'(virq), 0);
        chk("rst_iack", 32'(iack), 0);
        chk("rst_ivec", 32'(ivec), 0);
        chk("rst_req_ack", 32'(req_ack), 0);
        tick();
        tick();
        rst_n = 1'b1;

        // fixed priority: lines 2 and 5 pending
        req = 8'b0010_0100;
        tick();
        chk("fix_virq_pre", 32'(virq), 1);
        chk("fix_iack_pre", 32'(iack), 0);
        istb = 1'b1;
        tick();
        chk("fix1_ivec", 32'(ivec), 32'o000060);
        chk("fix1_iack", 32'(iack), 1);
        chk("fix1_req_ack", 32'(req_ack), 32'h04);
        chk("fix1_virq", 32'(virq), 0);
        req = 8'b0010_0000;
        tick();
        chk("fix1_req_ack_pulse", 32'(req_ack), 0);
        chk("fix1_ivec_hold", 32'(ivec), 32'o000060);
        chk("fix1_iack_hold", 32'(iack), 1);
        chk("fix1_virq_ack", 32'(virq), 0);
        tick();
        chk("fix1_iack_hold2", 32'(iack), 1);
        istb = 1'b0;
        tick();
        chk("fix1_iack_drop", 32'(iack), 0);
        chk("fix1_virq_reassert", 32'(virq), 1);
        istb = 1'b1;
        tick();
        chk("fix2_ivec", 32'(ivec), 32'o000064);
        chk("fix2_req_ack", 32'(req_ack), 32'h20);
        chk("fix2_iack", 32'(iack), 1);
        istb = 1'b0;
        req = '0;
        tick();
        chk("fix2_iack_drop", 32'(iack), 0);
        chk("fix2_virq", 32'(virq), 0);

        // request withdrawn before the strobe falls back to the spurious vector
        req = 8'h08;
        tick();
        chk("wd_virq", 32'(virq), 1);
        req = '0;
        tick();
        chk("wd_virq_drop", 32'(virq), 0);
        istb = 1'b1;
        tick();
        chk("wd_ivec", 32'(ivec), 0);
        chk("wd_iack", 32'(iack), 1);
        chk("wd_req_ack", 32'(req_ack), 0);
        istb = 1'b0;
        tick();

        // init while acknowledging with the strobe still high
        req = 8'h02;
        tick();
        chk("init_virq_pre", 32'(virq), 1);
        istb = 1'b1;
        tick();
        chk("init_grant_ivec", 32'(ivec), 32'o000104);
        chk("init_grant_req_ack", 32'(req_ack), 32'h02);
        init = 1'b1;
        tick();
        chk("init_iack", 32'(iack), 0);
        chk("init_req_ack", 32'(req_ack), 0);
        chk("init_virq", 32'(virq), 0);
        init = 1'b0;
        tick();
        chk("rel_iack", 32'(iack), 0);
        chk("rel_req_ack", 32'(req_ack), 0);
        chk("rel_virq", 32'(virq), 0);
        tick();
        chk("rel_iack2", 32'(iack), 0);
        istb = 1'b0;
        tick();
        chk("rel_exit_virq", 32'(virq), 1);
        istb = 1'b1;
        tick();
        chk("rel_regrant_iack", 32'(iack), 1);
        chk("rel_regrant_req_ack", 32'(req_ack), 32'h02);
        istb = 1'b0;
        req = '0;
        tick();

        // spurious strobe with nothing pending
        istb = 1'b1;
        tick();
        chk("spur_ivec", 32'(ivec), 32'o000000);
        chk("spur_iack", 32'(iack), 1);
        chk("spur_req_ack", 32'(req_ack), 0);
        chk("spur_virq", 32'(virq), 0);
        istb = 1'b0;
        tick();

        // asynchronous reset in the middle of an acknowledge
        req = 8'h10;
        tick();
        chk("ar_virq_pre", 32'(virq), 1);
        istb = 1'b1;
        tick();
        chk("ar_ivec_pre", 32'(ivec), 32'o000114);
        chk("ar_req_ack_pre", 32'(req_ack), 32'h10);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_iack", 32'(iack), 0);
        chk("ar_ivec", 32'(ivec), 0);
        chk("ar_req_ack", 32'(req_ack), 0);
        chk("ar_virq", 32'(virq), 0);
        istb = 1'b0;
        #1 rst_n = 1'b1;
        tick();
        chk("ar_virq_post", 32'(virq), 1);
        chk("ar_iack_post", 32'(iack), 0);
        req = '0;
        tick();

        // rotating priority: all lines pending, winners advance 0..3
        req_r = 8'hFF;
        tick();
        chk("rr_virq", 32'(virq_r), 1);
        for (int k = 0; k < 4; k++) begin
            istb_r = 1'b1;
            tick();
            chk($sformatf("rr_req_ack%0d", k), 32'(req_ack_r), 32'(8'h01 << k));
            chk($sformatf("rr_ivec%0d", k), 32'(ivec_r), 32'(vt[k]));
            istb_r = 1'b0;
            tick();
            chk($sformatf("rr_iack_drop%0d", k), 32'(iack_r), 0);
        end
        req_r = 8'h40;
        istb_r = 1'b1;
        tick();
        chk("rr_w6", 32'(req_ack_r), 32'h40);
        istb_r = 1'b0;
        req_r = 8'h81;
        tick();
        istb_r = 1'b1;
        tick();
        chk("rr_w7", 32'(req_ack_r), 32'h80);
        chk("rr_w7_ivec", 32'(ivec_r), 32'o000124);
        istb_r = 1'b0;
        tick();
        istb_r = 1'b1;
        tick();
        chk("rr_wrap0", 32'(req_ack_r), 32'h01);
        chk("rr_wrap0_ivec", 32'(ivec_r), 32'o000100);
        istb_r = 1'b0;
        tick();
        istb_r = 1'b1;
        tick();
        chk("rr_rot7", 32'(req_ack_r), 32'h80);
        istb_r = 1'b0;
        req_r = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
